// File: rtl/fetch_stage.sv
// Fetch stage of the multithreaded pipeline: picks one enabled hardware thread per cycle
// round-robin, keeps a PC per thread, and issues reads to a synchronous instruction memory.
module fetch_stage #(
    parameter int INSTR_WIDTH       = 32,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int PC_WIDTH          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_stall,
    input  logic [2**THREAD_INDEX_BITS-1:0] in_thread_enable,
    input  logic                         in_redirect_valid,
    input  logic [THREAD_INDEX_BITS-1:0] in_redirect_thread,
    input  logic [PC_WIDTH-1:0]          in_redirect_pc,
    output logic [PC_WIDTH-1:0]          out_imem_addr,
    input  logic [INSTR_WIDTH-1:0]       in_imem_data,
    output logic [INSTR_WIDTH-1:0]       out_instruction,
    output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
    output logic                         out_valid
);

    localparam int NUM_THREADS = 2**THREAD_INDEX_BITS;

    typedef logic [THREAD_INDEX_BITS-1:0] tid_t;
    typedef logic [PC_WIDTH-1:0]          pc_t;

    pc_t  pc_q [NUM_THREADS];
    pc_t  pc_d [NUM_THREADS];
    tid_t last_q, last_d;
    tid_t resp_thread_q, resp_thread_d;
    logic resp_valid_q, resp_valid_d;
    pc_t  addr_q, addr_d;

    tid_t sel;
    logic issue;
    logic redirect_hits_sel;
    logic redirect_hits_resp;

    // Scan last+1 .. last+NUM_THREADS; the final candidate wraps back onto last itself.
    always_comb begin
        tid_t cand;
        logic found;
        cand  = '0;
        found = 1'b0;
        sel   = last_q;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            cand = last_q + tid_t'(k);
            if (!found && in_thread_enable[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign issue              = (|in_thread_enable) && !in_stall;
    assign redirect_hits_sel  = in_redirect_valid && (in_redirect_thread == sel);
    assign redirect_hits_resp = in_redirect_valid && (in_redirect_thread == resp_thread_q);

    // The address is held while not issuing so memory data stays stable through a stall.
    assign out_imem_addr = issue ? pc_q[sel] : addr_q;
    assign addr_d        = out_imem_addr;

    // Redirect wins over the increment for the same thread.
    generate
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_pc_next
            assign pc_d[gi] = (in_redirect_valid && (in_redirect_thread == tid_t'(gi))) ? in_redirect_pc :
                              (issue && (sel == tid_t'(gi)))                            ? pc_q[gi] + pc_t'(1) :
                                                                                          pc_q[gi];
        end
    endgenerate

    always_comb begin
        last_d        = last_q;
        resp_thread_d = resp_thread_q;
        resp_valid_d  = 1'b0;
        if (issue) begin
            last_d        = sel;
            resp_thread_d = sel;
            resp_valid_d  = !redirect_hits_sel;
        end else if (in_stall) begin
            // Held response is invalidated if its thread gets redirected underneath it.
            resp_valid_d = resp_valid_q && !redirect_hits_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= '0;
            end
            last_q        <= tid_t'(NUM_THREADS - 1);
            resp_thread_q <= '0;
            resp_valid_q  <= 1'b0;
            addr_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
            last_q        <= last_d;
            resp_thread_q <= resp_thread_d;
            resp_valid_q  <= resp_valid_d;
            addr_q        <= addr_d;
        end
    end

    assign out_valid        = resp_valid_q;
    assign out_thread_index = resp_thread_q;
    assign out_instruction  = in_imem_data;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected {thread, pc} fetches,
// a negedge monitor pops and compares each newly presented valid output.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        in_stall;
    logic [7:0]  in_thread_enable;
    logic        in_redirect_valid;
    logic [2:0]  in_redirect_thread;
    logic [15:0] in_redirect_pc;
    logic [15:0] out_imem_addr;
    logic [31:0] in_imem_data;
    logic [31:0] out_instruction;
    logic [2:0]  out_thread_index;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  thr;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    logic stall_at_edge;

    fetch_stage #(
        .INSTR_WIDTH(32),
        .THREAD_INDEX_BITS(3),
        .PC_WIDTH(16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_stall          (in_stall),
        .in_thread_enable  (in_thread_enable),
        .in_redirect_valid (in_redirect_valid),
        .in_redirect_thread(in_redirect_thread),
        .in_redirect_pc    (in_redirect_pc),
        .out_imem_addr     (out_imem_addr),
        .in_imem_data      (in_imem_data),
        .out_instruction   (out_instruction),
        .out_thread_index  (out_thread_index),
        .out_valid         (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Synchronous instruction memory: data follows the address by one cycle.
    always @(posedge clk) begin
        in_imem_data  <= mem_word(out_imem_addr);
        stall_at_edge <= in_stall;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: a valid output is a new transaction unless the previous edge was stalled.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && stall_at_edge !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got thread %0d instr %0h expected none", out_thread_index, out_instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_thread", out_thread_index, e.thr);
                check("out_instr", out_instruction, mem_word(e.pc));
                $display("txn thread=%0d pc=%0h instr=%0h", out_thread_index, e.pc, out_instruction);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [7:0] en, input logic rv,
                         input logic [2:0] rt, input logic [15:0] rp);
        in_stall           = st;
        in_thread_enable   = en;
        in_redirect_valid  = rv;
        in_redirect_thread = rt;
        in_redirect_pc     = rp;
    endtask

    task automatic cycle_expect(input logic [7:0] en, input logic [2:0] thr, input logic [15:0] pc);
        exp_t e;
        drive(1'b0, en, 1'b0, 3'd0, 16'h0);
        #1;
        check("imem_addr", out_imem_addr, pc);
        e.thr = thr;
        e.pc  = pc;
        exp_q.push_back(e);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        stall_at_edge = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 3'd0, 16'h0);
        repeat (3) begin
            tick();
            check("valid_in_reset", out_valid, 1'b0);
        end
        check("thread_after_reset", out_thread_index, 3'd0);

        // Round-robin over all threads, two laps.
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle_expect(8'hFF, 3'(i % 8), 16'(i / 8));
        end

        // Sparse enable: threads 2 and 5.
        cycle_expect(8'h24, 3'd2, 16'd2);
        cycle_expect(8'h24, 3'd5, 16'd2);
        cycle_expect(8'h24, 3'd2, 16'd3);
        cycle_expect(8'h24, 3'd5, 16'd3);
        drive(1'b0, 8'h00, 1'b0, 3'd0, 16'h0);
        #1;
        check("addr_hold_idle", out_imem_addr, 16'd3);
        tick();
        check("valid_idle", out_valid, 1'b0);
        tick();
        check("valid_idle2", out_valid, 1'b0);
        cycle_expect(8'h24, 3'd2, 16'd4);

        // Stall for three cycles after issuing thread 3.
        cycle_expect(8'hFF, 3'd3, 16'd2);
        drive(1'b1, 8'hFF, 1'b0, 3'd0, 16'h0);
        #1;
        check("addr_hold_stall", out_imem_addr, 16'd2);
        repeat (3) begin
            tick();
            check("stall_valid", out_valid, 1'b1);
            check("stall_thread", out_thread_index, 3'd3);
            check("stall_instr", out_instruction, mem_word(16'd2));
        end
        cycle_expect(8'hFF, 3'd4, 16'd2);
        cycle_expect(8'hFF, 3'd5, 16'd4);
        cycle_expect(8'hFF, 3'd6, 16'd2);
        cycle_expect(8'hFF, 3'd7, 16'd2);

        // Redirect thread 0 in the cycle it is selected: fetch squashed.
        drive(1'b0, 8'hFF, 1'b1, 3'd0, 16'h0100);
        #1;
        check("addr_squashed", out_imem_addr, 16'd2);
        tick();
        check("valid_squashed", out_valid, 1'b0);
        cycle_expect(8'h01, 3'd0, 16'h0100);
        cycle_expect(8'h01, 3'd0, 16'h0101);
        cycle_expect(8'h01, 3'd0, 16'h0102);

        // Redirect of the thread held in the response registers during a stall.
        drive(1'b1, 8'h01, 1'b1, 3'd0, 16'h0200);
        tick();
        check("valid_redirect_held", out_valid, 1'b0);
        cycle_expect(8'h01, 3'd0, 16'h0200);

        // PC wrap on thread 3.
        drive(1'b0, 8'h00, 1'b1, 3'd3, 16'hFFFF);
        tick();
        check("valid_no_enable", out_valid, 1'b0);
        cycle_expect(8'h08, 3'd3, 16'hFFFF);
        cycle_expect(8'h08, 3'd3, 16'h0000);
        cycle_expect(8'h08, 3'd3, 16'h0001);

        // Reset while stalled with a valid output.
        cycle_expect(8'hFF, 3'd4, 16'd3);
        drive(1'b1, 8'hFF, 1'b0, 3'd0, 16'h0);
        tick();
        check("valid_stall_before_reset", out_valid, 1'b1);
        check("thread_stall_before_reset", out_thread_index, 3'd4);
        reset = 1'b1;
        tick();
        check("valid_reset_mid", out_valid, 1'b0);
        check("thread_reset_mid", out_thread_index, 3'd0);
        tick();
        reset = 1'b0;
        cycle_expect(8'hFF, 3'd0, 16'd0);
        cycle_expect(8'hFF, 3'd1, 16'd0);

        drive(1'b0, 8'h00, 1'b0, 3'd0, 16'h0);
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
